// File: rtl/bus_driver_fifo_pkg.sv
// Shared types and constants for the tri-state bus driver FIFO.
package bus_pkg;

  // Bus-side sequencing: idle (bus released), drive (head on bus), turnaround (bus released).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } bus_state_t;

  // Number of released cycles forced after every drive window.
  localparam int unsigned TURN_CYCLES = 1;

endpackage

// File: rtl/bus_driver_fifo_if.sv
// Producer handshake and bus grant/handshake signals of the bus driver FIFO.
interface bus_driver_fifo_if #(
  parameter int n = 16
);
  logic [n-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         cs;
  logic         bus_valid;
  logic         bus_take;

  // Environment side: producer plus bus arbiter/consumer.
  modport master (
    output in_data, in_valid, cs, bus_take,
    input  in_ready, bus_valid
  );

  // Block side.
  modport slave (
    input  in_data, in_valid, cs, bus_take,
    output in_ready, bus_valid
  );
endinterface

// File: rtl/bus_driver_fifo_sync_fifo.sv
// Synchronous FIFO: storage, pointers, occupancy and registered full/empty flags.
module sync_fifo
  import bus_pkg::*;
#(
  parameter  int n     = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [n-1:0]  wr_data,
  output logic [n-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [n-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;

  // Word storage carries data only, so it is never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Occupancy after this cycle's push/pop; a simultaneous pair cancels out.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; flags are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/bus_driver_fifo.sv
// FIFO-backed tri-state bus source: drives the shared bus only while granted,
// with a forced turnaround cycle after every drive window.
module bus_driver_fifo
  import bus_pkg::*;
#(
  parameter  int n     = 16,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  bus_driver_fifo_if.slave  link,
  output logic [n-1:0]      bus,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  bus_state_t   state;
  bus_state_t   state_nxt;
  logic         drive;
  logic         push;
  logic         pop;
  logic [n-1:0] head;

  assign push = link.in_valid && !full && !rst;
  assign pop  = drive && link.bus_take && !rst;

  sync_fifo #(
    .n     (n),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (link.in_data),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // State register for the drive/turnaround sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and drive enable; leaving DRIVE still lets the current pop complete.
  always_comb begin
    state_nxt = state;
    drive     = 1'b0;
    unique case (state)
      IDLE: begin
        if (link.cs && !empty) begin
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        drive = 1'b1;
        if (!link.cs || (pop && (count == CW'(1)) && !push)) begin
          state_nxt = TURN;
        end
      end
      TURN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign link.bus_valid = drive;
  assign link.in_ready  = !full;

  // Bus enable comes from registered state only, never directly from cs.
  assign bus = drive ? head : {n{1'bz}};

endmodule
